// File: rtl/load_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_serializer: 2-deep row FIFO feeding a row-to-beat serializer with      |
// | optional inter-row gap and frame counting.          Revision: 1.0          |
// +----------------------------------------------------------------------------+
module load_serializer #(
  parameter int WIDTH_ROW      = 256,
  parameter int WIDTH_WORD     = 32,
  parameter int ROWS_PER_FRAME = 16,
  parameter int GAP_CYCLES     = 0,
  parameter int MSW_FIRST      = 0
) (
  input  logic                              clk_data,
  input  logic                              rst_n,
  input  logic                              row_valid_i,
  input  logic [WIDTH_ROW-1:0]              row_data_i,
  output logic                              row_ready_o,
  output logic                              load_en_o,
  output logic [WIDTH_WORD-1:0]             load_payload_o,
  output logic                              busy_o,
  output logic [$clog2(ROWS_PER_FRAME)-1:0] row_cnt_o,
  output logic                              frame_done_o
);

  localparam int BEATS = WIDTH_ROW / WIDTH_WORD;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(ROWS_PER_FRAME);
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [GW-1:0] GAP_INIT  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_LAST  = CW'(ROWS_PER_FRAME - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [WIDTH_ROW-1:0]  row_q, row_d;
  logic [WIDTH_ROW-1:0]  mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic [CW-1:0]         row_cnt_q, row_cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic                  load_en_q, load_en_d;
  logic [WIDTH_WORD-1:0] payload_q, payload_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;

  logic                  w_push, w_pop, w_last;
  logic [BW-1:0]         w_idx;
  logic [WIDTH_WORD-1:0] w_words [BEATS];

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign w_push = row_valid_i && (count_q != 2'd2);
  assign w_last = (state_q == S_SEND) && (beat_q == LAST_BEAT);

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    w_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) begin
          w_pop   = 1'b1;
          state_d = S_SEND;
          beat_d  = '0;
        end
      end
      S_SEND: begin
        if (beat_q == LAST_BEAT) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_INIT;
          end else if (count_q != 2'd0) begin
            w_pop  = 1'b1;
            beat_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (count_q != 2'd0) begin
          w_pop   = 1'b1;
          state_d = S_SEND;
          beat_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar k = 0; k < BEATS; k++) begin : g_word
    assign w_words[k] = row_d[k*WIDTH_WORD +: WIDTH_WORD];
  end

  always_comb begin
    count_d      = count_q + {1'b0, w_push} - {1'b0, w_pop};
    row_d        = w_pop ? mem_q[rd_ptr_q] : row_q;
    row_cnt_d    = row_cnt_q;
    frame_done_d = 1'b0;
    if (w_last) begin
      if (row_cnt_q == CNT_LAST) begin
        row_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end
    load_en_d = (state_d == S_SEND);
    w_idx     = (MSW_FIRST != 0) ? (LAST_BEAT - beat_d) : beat_d;
    payload_d = load_en_d ? w_words[w_idx] : '0;
    busy_d    = (state_d != S_IDLE) || (count_d != 2'd0);
    ready_d   = (count_d != 2'd2);
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      beat_q       <= '0;
      gap_q        <= '0;
      row_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      row_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      load_en_q    <= 1'b0;
      payload_q    <= '0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      row_q        <= row_d;
      wr_ptr_q     <= wr_ptr_q ^ w_push;
      rd_ptr_q     <= rd_ptr_q ^ w_pop;
      count_q      <= count_d;
      row_cnt_q    <= row_cnt_d;
      frame_done_q <= frame_done_d;
      load_en_q    <= load_en_d;
      payload_q    <= payload_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  always_ff @(posedge clk_data) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= row_data_i;
    end
  end

  assign row_ready_o    = ready_q;
  assign load_en_o      = load_en_q;
  assign load_payload_o = payload_q;
  assign busy_o         = busy_q;
  assign row_cnt_o      = row_cnt_q;
  assign frame_done_o   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_load_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_load_serializer: two serializer instances (defaults / gap+MSW-first)    |
// | against a beat-stream scoreboard.                    Revision: 1.0         |
// +----------------------------------------------------------------------------+
module tb_load_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         row_valid [2];
  logic [255:0] row_data  [2];
  logic         row_ready [2];
  logic         load_en   [2];
  logic [31:0]  payload   [2];
  logic         busy      [2];
  logic         fd        [2];
  logic [3:0]   rc0;
  logic [1:0]   rc1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [2][$];
  int          beat_start [2][$];
  int          bir [2];
  int          exp_rc [2];
  bit          exp_fd [2];
  int          gap_left [2];
  int          fd_pulses [2];
  int          beats_total [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_serializer u_dut0 (
    .clk_data(clk), .rst_n(rst_n),
    .row_valid_i(row_valid[0]), .row_data_i(row_data[0]), .row_ready_o(row_ready[0]),
    .load_en_o(load_en[0]), .load_payload_o(payload[0]), .busy_o(busy[0]),
    .row_cnt_o(rc0), .frame_done_o(fd[0])
  );

  load_serializer #(.ROWS_PER_FRAME(4), .GAP_CYCLES(3), .MSW_FIRST(1)) u_dut1 (
    .clk_data(clk), .rst_n(rst_n),
    .row_valid_i(row_valid[1]), .row_data_i(row_data[1]), .row_ready_o(row_ready[1]),
    .load_en_o(load_en[1]), .load_payload_o(payload[1]), .busy_o(busy[1]),
    .row_cnt_o(rc1), .frame_done_o(fd[1])
  );

  function automatic int gap_of(input int i);
    return (i == 1) ? 3 : 0;
  endfunction
  function automatic int rpf_of(input int i);
    return (i == 1) ? 4 : 16;
  endfunction
  function automatic bit msw_of(input int i);
    return (i == 1);
  endfunction
  function automatic logic [3:0] get_rc(input int i);
    return (i == 0) ? rc0 : {2'b00, rc1};
  endfunction

  task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [255:0] rand_row();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Expected beats are queued at acceptance, in the order the beat-order rule dictates.
  task automatic push_row(input int i, input logic [255:0] d, output int acc);
    bit ok;
    bit r;
    ok  = 1'b0;
    acc = -1;
    row_valid[i] = 1'b1;
    row_data[i]  = d;
    for (int n = 0; n < 300 && !ok; n++) begin
      r = row_ready[i];
      step();
      if (r) ok = 1'b1;
    end
    row_valid[i] = 1'b0;
    if (ok) begin
      acc = cyc;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = msw_of(i) ? 7 - k : k;
        exp_q[i].push_back(d[32*idx +: 32]);
      end
    end else begin
      check_eq($sformatf("push_timeout%0d", i), 0, 1);
    end
  endtask

  task automatic wait_idle(input int i);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (exp_q[i].size() == 0 && !busy[i]) done = 1'b1;
      else step();
    end
    if (!done) check_eq($sformatf("idle_timeout%0d", i), 0, 1);
    repeat (3) step();
  endtask

  task automatic chk_reset(input int i);
    check_eq($sformatf("rst_ready%0d", i),   row_ready[i], 1);
    check_eq($sformatf("rst_load_en%0d", i), load_en[i],   0);
    check_eq($sformatf("rst_payload%0d", i), payload[i],   0);
    check_eq($sformatf("rst_busy%0d", i),    busy[i],      0);
    check_eq($sformatf("rst_row_cnt%0d", i), get_rc(i),    0);
    check_eq($sformatf("rst_frame%0d", i),   fd[i],        0);
  endtask

  task automatic flush_models();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      beat_start[i].delete();
      bir[i] = 0; exp_rc[i] = 0; exp_fd[i] = 1'b0; gap_left[i] = 0;
      fd_pulses[i] = 0; beats_total[i] = 0;
    end
  endtask

  // Monitor: frame/row count/busy each cycle, beat payloads against the scoreboard.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      if (rst_n) begin
        check_eq($sformatf("row_cnt%0d", g), get_rc(g), exp_rc[g]);
        check_eq($sformatf("frame_done%0d", g), fd[g], exp_fd[g]);
        check_eq($sformatf("busy%0d", g), busy[g], (exp_q[g].size() != 0) || (gap_left[g] > 0));
        if (fd[g]) fd_pulses[g]++;
        exp_fd[g] = 1'b0;
        if (load_en[g]) begin
          beats_total[g]++;
          check_eq($sformatf("gap_violation%0d", g), gap_left[g], 0);
          if (exp_q[g].size() == 0) begin
            check_eq($sformatf("unexpected_beat%0d", g), payload[g], 0);
            check_eq($sformatf("unexpected_beat_flag%0d", g), 1, 0);
          end else begin
            check_eq($sformatf("payload%0d", g), payload[g], exp_q[g].pop_front());
          end
          if (bir[g] == 0) beat_start[g].push_back(cyc);
          bir[g]++;
          if (bir[g] == 8) begin
            bir[g]      = 0;
            exp_rc[g]   = (exp_rc[g] + 1) % rpf_of(g);
            exp_fd[g]   = (exp_rc[g] == 0);
            gap_left[g] = gap_of(g);
          end
        end else if (gap_left[g] > 0) begin
          gap_left[g]--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] pat;
    int  acc;
    int  acc_first;
    bit  hit;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      row_valid[i] = 1'b0;
      row_data[i]  = '0;
    end
    flush_models();
    for (int k = 0; k < 8; k++) pat[32*k +: 32] = 32'h11111111 * k;

    repeat (3) @(posedge clk);
    #2;
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    step();

    // Single row, LSW first: latency and return to idle.
    beat_start[0].delete();
    push_row(0, pat, acc);
    wait_idle(0);
    check_eq("single_rows", beat_start[0].size(), 1);
    if (beat_start[0].size() == 1) check_eq("single_latency", beat_start[0][0], acc + 1);
    check_eq("single_row_cnt", get_rc(0), 1);
    check_eq("single_busy", busy[0], 0);

    // Three rows back-to-back with valid held high.
    beat_start[0].delete();
    push_row(0, rand_row(), acc);
    push_row(0, rand_row(), acc);
    push_row(0, rand_row(), acc);
    check_eq("b2b_ready_full", row_ready[0], 0);
    wait_idle(0);
    check_eq("b2b_ready_back", row_ready[0], 1);
    check_eq("b2b_rows", beat_start[0].size(), 3);
    if (beat_start[0].size() == 3) begin
      check_eq("b2b_contig01", beat_start[0][1] - beat_start[0][0], 8);
      check_eq("b2b_contig12", beat_start[0][2] - beat_start[0][1], 8);
    end

    // MSW-first instance with gap: same pattern, then two queued rows.
    push_row(1, pat, acc);
    wait_idle(1);
    beat_start[1].delete();
    push_row(1, rand_row(), acc);
    push_row(1, rand_row(), acc);
    wait_idle(1);
    check_eq("gap_rows", beat_start[1].size(), 2);
    if (beat_start[1].size() == 2) check_eq("gap_spacing", beat_start[1][1] - beat_start[1][0], 11);

    // Reset during beat 3 with a second row queued.
    push_row(0, rand_row(), acc_first);
    push_row(0, rand_row(), acc);
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      #1;
      if (bir[0] == 4) hit = 1'b1;
    end
    check_eq("reset_beat3_reached", hit, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    flush_models();
    step();
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check_eq("post_reset_silence", beats_total[0], 0);
    check_eq("post_reset_busy", busy[0], 0);

    // Frame: 17 rows on the default instance, 6 on the alternate one, random spacing.
    fork
      begin
        int a0;
        for (int r = 0; r < 17; r++) begin
          repeat ($urandom_range(0, 3)) step();
          push_row(0, rand_row(), a0);
        end
      end
      begin
        int a1;
        for (int r = 0; r < 6; r++) begin
          repeat ($urandom_range(0, 12)) step();
          push_row(1, rand_row(), a1);
        end
      end
    join
    wait_idle(0);
    wait_idle(1);
    check_eq("frame_pulses0", fd_pulses[0], 1);
    check_eq("frame_row_cnt0", get_rc(0), 1);
    check_eq("frame_beats0", beats_total[0], 17 * 8);
    check_eq("frame_pulses1", fd_pulses[1], 1);
    check_eq("frame_row_cnt1", get_rc(1), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
